sp_link_ctrl: RTL and testbench

Link-synchronisation controller that sits directly behind the serial-to-parallel deserializer on the receive side. It enables and re-arms the deserializer and watches the recovered byte stream for the 0xBC comma. It declares lock after a run of consecutive commas, then forwards only data bytes downstream with a valid strobe. It detects loss of byte framing, drops back to hunting, and keeps a saturating count of lock losses for status.

---
 rtl/sp_link_pkg.sv | 24 ++
 rtl/sp_link_if.sv | 24 ++
 rtl/sp_stb_watchdog.sv | 34 +++
 rtl/sp_link_ctrl.sv | 129 ++++++++++++
 tb/tb_sp_link_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sp_link_pkg.sv
// Shared definitions for the receive-side link synchronisation controller.
package sp_link_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HUNT  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_LOCK  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_HUNT  = ST_HUNT,
    S_CHECK = ST_CHECK,
    S_LOCK  = ST_LOCK
  } state_e;

  localparam logic [7:0] COMMA_DEF       = 8'hBC;
  localparam int         LOCK_COUNT_DEF  = 4;
  localparam int         STB_TIMEOUT_DEF = 12;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sp_link_if.sv
// Deserializer-side handshake and status bundle of the link controller.
interface sp_link_if;
  logic       enable;
  logic       resync_req;
  logic [7:0] byte_in;
  logic       byte_stb;
  logic       sp_en;
  logic       sp_realign;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [1:0] state;
  logic [7:0] loss_cnt;

  modport master (
    output enable, resync_req, byte_in, byte_stb,
    input  sp_en, sp_realign, data_out, valid_out, active, state, loss_cnt
  );

  modport slave (
    input  enable, resync_req, byte_in, byte_stb,
    output sp_en, sp_realign, data_out, valid_out, active, state, loss_cnt
  );
endinterface

// File: rtl/sp_stb_watchdog.sv
// Byte-strobe watchdog: counts cycles since the last clear, pulses tmo_o when
// the count reaches STB_TIMEOUT.
module sp_stb_watchdog #(
  parameter  int STB_TIMEOUT = 12,
  localparam int W           = $clog2(STB_TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tmo_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + W'(1);
  end

  // A strobe in the final cycle clears the count, so it still counts as in time.
  assign tmo_o = en_i && !clr_i && (cnt_d == W'(STB_TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sp_link_ctrl.sv
// Comma-based link synchronisation: hunts for lock, strips idle commas,
// forwards data bytes and counts lock losses.
//
// state | meaning
// IDLE  | link disabled, deserializer off
// HUNT  | deserializer on, waiting for the first comma
// CHECK | counting consecutive commas toward lock
// LOCK  | framed; data bytes forwarded, commas stripped
module sp_link_ctrl
  import sp_link_pkg::*;
#(
  parameter logic [7:0] COMMA       = COMMA_DEF,
  parameter int         LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int         STB_TIMEOUT = STB_TIMEOUT_DEF
) (
  input logic      clk_32f,
  input logic      reset_L,
  sp_link_if.slave link
);

  state_e     state_q, state_d;
  logic [2:0] comma_q, comma_d, comma_inc;
  logic [7:0] data_q, data_d;
  logic [7:0] loss_q, loss_d;
  logic       valid_q, valid_d;
  logic       realign_q, realign_d;
  logic       sp_en_q, active_q;
  logic       is_comma, wd_en, wd_clr, tmo;

  assign is_comma  = (link.byte_in == COMMA);
  assign comma_inc = comma_q + 3'd1;

  // IDLE/HUNT hold the watchdog cleared, so every entry to CHECK/LOCK starts at 0.
  assign wd_en  = (state_q == S_CHECK) || (state_q == S_LOCK);
  assign wd_clr = link.byte_stb || !wd_en || !link.enable;

  sp_stb_watchdog #(.STB_TIMEOUT(STB_TIMEOUT)) u_wdog (
    .clk_i   (clk_32f),
    .rst_n_i (reset_L),
    .clr_i   (wd_clr),
    .en_i    (wd_en),
    .tmo_o   (tmo)
  );

  always_comb begin
    state_d   = state_q;
    comma_d   = comma_q;
    data_d    = data_q;
    loss_d    = loss_q;
    valid_d   = 1'b0;
    realign_d = 1'b0;

    if (!link.enable) begin
      state_d = S_IDLE;
      comma_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d   = S_HUNT;
          realign_d = 1'b1;
          comma_d   = '0;
        end
        S_HUNT: begin
          if (link.resync_req) begin
            realign_d = 1'b1;
            comma_d   = '0;
          end else if (link.byte_stb && is_comma) begin
            comma_d = 3'd1;
            state_d = (LOCK_COUNT == 1) ? S_LOCK : S_CHECK;
          end
        end
        S_CHECK: begin
          if (link.resync_req || tmo || (link.byte_stb && !is_comma)) begin
            state_d   = S_HUNT;
            realign_d = 1'b1;
            comma_d   = '0;
          end else if (link.byte_stb) begin
            comma_d = comma_inc;
            if (comma_inc == 3'(LOCK_COUNT))
              state_d = S_LOCK;
          end
        end
        S_LOCK: begin
          if (link.resync_req || tmo) begin
            state_d   = S_HUNT;
            realign_d = 1'b1;
            comma_d   = '0;
            loss_d    = sat_inc8(loss_q);
          end else if (link.byte_stb && !is_comma) begin
            data_d  = link.byte_in;
            valid_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= S_IDLE;
      comma_q   <= '0;
      data_q    <= '0;
      loss_q    <= '0;
      valid_q   <= 1'b0;
      realign_q <= 1'b0;
      sp_en_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      comma_q   <= comma_d;
      data_q    <= data_d;
      loss_q    <= loss_d;
      valid_q   <= valid_d;
      realign_q <= realign_d;
      sp_en_q   <= (state_d != S_IDLE);
      active_q  <= (state_d == S_LOCK);
    end
  end

  assign link.sp_en      = sp_en_q;
  assign link.sp_realign = realign_q;
  assign link.data_out   = data_q;
  assign link.valid_out  = valid_q;
  assign link.active     = active_q;
  assign link.state      = state_q;
  assign link.loss_cnt   = loss_q;

endmodule

// File: tb/tb_sp_link_ctrl.sv
// Directed bench for sp_link_ctrl with a scoreboard of forwarded data bytes.
module tb_sp_link_ctrl;

  localparam logic [1:0] IDLE = 2'd0, HUNT = 2'd1, CHECK = 2'd2, LOCK = 2'd3;
  localparam logic [7:0] BC = 8'hBC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   vcnt = 0;
  int   rcnt = 0;
  int   v0, r0;
  logic [7:0] exp_q[$];

  sp_link_if link();

  sp_link_ctrl dut (
    .clk_32f (clk),
    .reset_L (rst_n),
    .link    (link)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (link.sp_realign === 1'b1) rcnt++;
    if (link.valid_out === 1'b1) begin
      vcnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_valid observed data=%0h expected no valid_out", link.data_out);
      end
      if (exp_q.size() != 0) chk("data_out", 32'(link.data_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit fwd, input logic [1:0] exp_st, input string tag);
    if (fwd) exp_q.push_back(b);
    link.byte_in  = b;
    link.byte_stb = 1'b1;
    tick();
    link.byte_stb = 1'b0;
    chk(tag, 32'(link.state), 32'(exp_st));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    link.enable     = 1'b0;
    link.resync_req = 1'b0;
    link.byte_in    = 8'h00;
    link.byte_stb   = 1'b0;

    #12;
    chk("rst_state",   32'(link.state), 32'(IDLE));
    chk("rst_sp_en",   32'(link.sp_en), 0);
    chk("rst_active",  32'(link.active), 0);
    chk("rst_valid",   32'(link.valid_out), 0);
    chk("rst_realign", 32'(link.sp_realign), 0);
    chk("rst_data",    32'(link.data_out), 0);
    chk("rst_loss",    32'(link.loss_cnt), 0);

    #20 rst_n = 1'b1;
    tick();
    r0 = rcnt;
    v0 = vcnt;
    link.enable = 1'b1;
    tick();
    chk("en_state",   32'(link.state), 32'(HUNT));
    chk("en_realign", 32'(link.sp_realign), 1);
    chk("en_sp_en",   32'(link.sp_en), 1);
    tick();
    chk("en_realign_off", 32'(link.sp_realign), 0);

    // Basic lock and forwarding with 8-cycle strobe spacing.
    send(BC, 0, CHECK, "t1_bc1"); idle(7);
    send(BC, 0, CHECK, "t1_bc2"); idle(7);
    send(BC, 0, CHECK, "t1_bc3"); chk("t1_active_pre", 32'(link.active), 0); idle(7);
    send(BC, 0, LOCK,  "t1_bc4"); chk("t1_active", 32'(link.active), 1); idle(7);
    send(8'h5A, 1, LOCK, "t1_5a"); idle(7);
    send(BC, 0, LOCK, "t1_strip"); chk("t1_hold", 32'(link.data_out), 32'h5A); idle(7);
    send(8'h3C, 1, LOCK, "t1_3c"); idle(7);
    chk("t1_valid_cnt",   32'(vcnt - v0), 2);
    chk("t1_q_empty",     32'(exp_q.size()), 0);
    chk("t1_data_hold",   32'(link.data_out), 32'h3C);
    chk("t1_realign_cnt", 32'(rcnt - r0), 1);

    // Strobes stop: lock lost 12 cycles after the last strobe.
    idle(4);
    chk("to_active_11", 32'(link.active), 1);
    chk("to_state_11",  32'(link.state), 32'(LOCK));
    tick();
    chk("to_active_12", 32'(link.active), 0);
    chk("to_state_12",  32'(link.state), 32'(HUNT));
    chk("to_realign",   32'(link.sp_realign), 1);
    chk("to_loss",      32'(link.loss_cnt), 1);
    idle(3);

    // Broken comma run restarts the hunt.
    r0 = rcnt;
    send(BC, 0, CHECK, "t2_bc1"); idle(7);
    send(BC, 0, CHECK, "t2_bc2"); idle(7);
    send(8'h11, 0, HUNT, "t2_11"); chk("t2_realign", 32'(link.sp_realign), 1); idle(7);
    send(BC, 0, CHECK, "t2_bc3"); idle(7);
    send(BC, 0, CHECK, "t2_bc4"); idle(7);
    send(BC, 0, CHECK, "t2_bc5"); idle(7);
    send(BC, 0, LOCK,  "t2_bc6"); idle(7);
    chk("t2_realign_cnt", 32'(rcnt - r0), 1);

    // Resync beats a same-cycle data strobe.
    link.byte_in    = 8'h77;
    link.byte_stb   = 1'b1;
    link.resync_req = 1'b1;
    tick();
    link.byte_stb   = 1'b0;
    link.resync_req = 1'b0;
    chk("rs_state",   32'(link.state), 32'(HUNT));
    chk("rs_realign", 32'(link.sp_realign), 1);
    chk("rs_valid",   32'(link.valid_out), 0);
    chk("rs_loss",    32'(link.loss_cnt), 2);
    idle(2);

    // Disable while locked.
    send(BC, 0, CHECK, "dis_bc1"); idle(7);
    send(BC, 0, CHECK, "dis_bc2"); idle(7);
    send(BC, 0, CHECK, "dis_bc3"); idle(7);
    send(BC, 0, LOCK,  "dis_bc4"); idle(7);
    send(8'h42, 1, LOCK, "dis_42"); idle(2);
    r0 = rcnt;
    link.enable = 1'b0;
    tick();
    chk("dis_state",   32'(link.state), 32'(IDLE));
    chk("dis_sp_en",   32'(link.sp_en), 0);
    chk("dis_active",  32'(link.active), 0);
    chk("dis_realign", 32'(link.sp_realign), 0);
    chk("dis_loss",    32'(link.loss_cnt), 2);
    idle(2);
    chk("dis_realign_cnt", 32'(rcnt - r0), 0);

    // 300 rapid lock/resync cycles saturate the loss counter.
    link.enable = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      link.byte_in  = BC;
      link.byte_stb = 1'b1;
      idle(4);
      link.byte_stb   = 1'b0;
      link.resync_req = 1'b1;
      tick();
      link.resync_req = 1'b0;
    end
    chk("sat_loss",  32'(link.loss_cnt), 255);
    chk("sat_state", 32'(link.state), 32'(HUNT));
    send(BC, 0, CHECK, "sat_bc1");
    send(BC, 0, CHECK, "sat_bc2");
    send(BC, 0, CHECK, "sat_bc3");
    send(BC, 0, LOCK,  "sat_bc4");
    chk("sat_active", 32'(link.active), 1);
    chk("sat_loss2",  32'(link.loss_cnt), 255);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("ar_state",   32'(link.state), 32'(IDLE));
    chk("ar_active",  32'(link.active), 0);
    chk("ar_sp_en",   32'(link.sp_en), 0);
    chk("ar_loss",    32'(link.loss_cnt), 0);
    chk("ar_data",    32'(link.data_out), 0);
    chk("ar_valid",   32'(link.valid_out), 0);
    chk("ar_realign", 32'(link.sp_realign), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_restart_state",   32'(link.state), 32'(HUNT));
    chk("ar_restart_realign", 32'(link.sp_realign), 1);
    chk("ar_restart_loss",    32'(link.loss_cnt), 0);
    idle(2);
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
